// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for the weight-stationary systolic array.
// Walks one tile through weight preload, skewed activation streaming,
// pipeline drain and a two-phase handshaked readout of the output groups.
// Every output is a decode of the registered state, counter and latched
// tile length, so no input reaches an output in the same cycle.
module systolic_array_ctrl #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SKEW      = 2,
  parameter int DRAIN_CYC = ROWS + COLS + 2,
  parameter int KW        = 8,
  parameter int CW        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     abort,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     w_rd_en,
  output logic [$clog2(ROWS)-1:0]  w_rd_addr,
  output logic                     a_rd_en,
  output logic [CW-1:0]            a_rd_addr,
  output logic [ROWS-1:0]          row_valid,
  output logic                     sa_enable,
  output logic                     sa_load_w,
  output logic                     sa_group_sel,
  output logic                     res_valid,
  output logic                     res_group
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    OUT_LO,
    OUT_HI,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [KW-1:0] k_lat, k_d;
  logic          err_q, err_d;

  // Last counter value of STREAM: the final lane needs SKEW*(ROWS-1) extra
  // cycles beyond the k_len activation vectors.
  logic [CW-1:0] stream_last;
  assign stream_last = CW'(k_lat) + CW'(SKEW * (ROWS - 1)) - CW'(1);

  // State, phase counter, latched tile length and the registered error pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      k_lat <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      k_lat <= k_d;
      err_q <= err_d;
    end
  end

  // Next-state and counter sequencing; abort outranks every other transition.
  // NOTE: every variable gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    k_d     = k_lat;
    err_d   = 1'b0;
    if (state != IDLE && abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (k_len == '0) begin
              err_d = 1'b1;
            end else begin
              k_d     = k_len;
              state_d = LOAD_W;
              cnt_d   = '0;
            end
          end
        end
        LOAD_W: begin
          if (cnt == CW'(ROWS - 1)) begin
            state_d = STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        STREAM: begin
          if (cnt == stream_last) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (cnt == CW'(DRAIN_CYC - 1)) begin
            state_d = OUT_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        // In the readout states cnt==0 marks the settle cycle; afterwards it
        // parks at 1 while the group is presented.
        OUT_LO: begin
          if (cnt == '0) begin
            cnt_d = CW'(1);
          end else if (res_ready) begin
            state_d = OUT_HI;
            cnt_d   = '0;
          end
        end
        OUT_HI: begin
          if (cnt == '0) begin
            cnt_d = CW'(1);
          end else if (res_ready) begin
            state_d = DONE;
            cnt_d   = '0;
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore output decode from state, counter and latched tile length.
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    err          = err_q;
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    a_rd_en      = 1'b0;
    a_rd_addr    = '0;
    row_valid    = '0;
    sa_enable    = 1'b0;
    sa_load_w    = 1'b0;
    sa_group_sel = 1'b0;
    res_valid    = 1'b0;
    res_group    = 1'b0;
    case (state)
      LOAD_W: begin
        sa_enable = 1'b1;
        sa_load_w = 1'b1;
        w_rd_en   = 1'b1;
        w_rd_addr = cnt[$clog2(ROWS)-1:0];
      end
      STREAM: begin
        sa_enable = 1'b1;
        a_rd_addr = cnt;
        for (int r = 0; r < ROWS; r++) begin
          row_valid[r] = (cnt >= CW'(SKEW * r)) &&
                         (cnt < CW'(SKEW * r) + CW'(k_lat));
        end
        a_rd_en = |row_valid;
      end
      DRAIN: begin
        sa_enable = 1'b1;
      end
      OUT_LO: begin
        res_valid = (cnt != '0);
      end
      OUT_HI: begin
        sa_group_sel = 1'b1;
        res_group    = 1'b1;
        res_valid    = (cnt != '0);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl.
// A timeline model (tile start cycle, tile length, handshake cycles) predicts
// every output each cycle; table-driven tiles and hand-written corner
// sequences add targeted checks on top, followed by a randomized run.
module tb_systolic_array_ctrl;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int SKEW  = 2;
  localparam int DRAIN = ROWS + COLS + 2;
  localparam int KW    = 8;
  localparam int CW    = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            abort;
  logic            res_ready;
  logic            busy, done, err, w_rd_en, a_rd_en;
  logic [2:0]      w_rd_addr;
  logic [CW-1:0]   a_rd_addr;
  logic [ROWS-1:0] row_valid;
  logic            sa_enable, sa_load_w, sa_group_sel, res_valid, res_group;

  systolic_array_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SKEW(SKEW), .DRAIN_CYC(DRAIN), .KW(KW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .res_ready(res_ready), .busy(busy), .done(done), .err(err),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .a_rd_en(a_rd_en),
    .a_rd_addr(a_rd_addr), .row_valid(row_valid), .sa_enable(sa_enable),
    .sa_load_w(sa_load_w), .sa_group_sel(sa_group_sel),
    .res_valid(res_valid), .res_group(res_group)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [36:0] dut_vec;
  assign dut_vec = {busy, done, err, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
                    row_valid, sa_enable, sa_load_w, sa_group_sel, res_valid,
                    res_group};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Timeline model of the tile in flight.
  bit          m_active  = 0;
  int          m_t0      = 0;   // first LOAD_W cycle
  int          m_k       = 0;
  int          m_hs_lo   = -1;  // first OUT_HI cycle once the low group is taken
  int          m_hs_hi   = -1;  // DONE cycle once the high group is taken
  int          m_err_cyc = -1;
  logic [36:0] cur_exp   = '0;

  int t_acc = 0;  // edge index at which the current tile was accepted
  int t_k   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [36:0] model_out(input int c);
    logic          b = 0, dn = 0, er = 0, wen = 0, aen = 0;
    logic [2:0]    wad = 0;
    logic [CW-1:0] aad = 0;
    logic [ROWS-1:0] rv = 0;
    logic          en = 0, ld = 0, sel = 0, rvld = 0, grp = 0;
    int d, len, s;
    er = (c == m_err_cyc);
    if (m_active) begin
      b   = 1;
      d   = c - m_t0;
      len = m_k + SKEW * (ROWS - 1);
      if (d < ROWS) begin
        en = 1; ld = 1; wen = 1; wad = 3'(d);
      end else if (d < ROWS + len) begin
        s   = d - ROWS;
        en  = 1;
        aad = CW'(s);
        for (int r = 0; r < ROWS; r++)
          rv[r] = (s >= SKEW * r) && (s < SKEW * r + m_k);
        aen = (rv != 0);
      end else if (d < ROWS + len + DRAIN) begin
        en = 1;
      end else if (m_hs_lo < 0) begin
        rvld = (c > m_t0 + ROWS + len + DRAIN);
      end else if (m_hs_hi < 0) begin
        sel = 1; grp = 1;
        rvld = (c > m_hs_lo);
      end else begin
        dn = 1;
      end
    end
    return {b, dn, er, wen, wad, aen, aad, rv, en, ld, sel, rvld, grp};
  endfunction

  // Advance the model over one clock edge using the inputs seen at that edge.
  task automatic model_edge(input int n);
    logic prev_busy, prev_done, prev_valid;
    prev_busy  = cur_exp[36];
    prev_done  = cur_exp[35];
    prev_valid = cur_exp[1];
    if (prev_busy) begin
      if (abort) m_active = 0;
      else if (prev_done) m_active = 0;
      else if (prev_valid && res_ready) begin
        if (m_hs_lo < 0) m_hs_lo = n;
        else m_hs_hi = n;
      end
    end else if (start) begin
      if (k_len == 0) m_err_cyc = n;
      else begin
        m_active = 1; m_t0 = n; m_k = int'(k_len); m_hs_lo = -1; m_hs_hi = -1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge(cyc + 1);
    cyc++;
    cur_exp = model_out(cyc);
    @(negedge clk);
    check("outputs", 64'(dut_vec), 64'(cur_exp));
  endtask

  task automatic model_reset();
    m_active = 0; m_err_cyc = -1; cur_exp = '0;
  endtask

  // Assert reset mid-cycle, check the outputs drop at once, release at negedge.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1 check("async_rst_outputs", 64'(dut_vec), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_tile(input int k);
    start = 1'b1; k_len = KW'(k);
    step();
    start = 1'b0; k_len = KW'($urandom);
    t_acc = cyc - 1; t_k = k;
  endtask

  task automatic run_to_done(input int budget, input int stall, output int done_rel,
                             output int rv0, output int rv7, output int r7_first);
    int rel;
    done_rel = -1; rv0 = 0; rv7 = 0; r7_first = -1;
    for (int i = 0; i < budget; i++) begin
      rel = cyc - t_acc;
      res_ready = !((rel >= t_k + 42) && (rel < t_k + 42 + stall));
      step();
      rel = cyc - t_acc;
      if (row_valid[0]) rv0++;
      if (row_valid[7]) begin
        rv7++;
        if (r7_first < 0) r7_first = rel;
      end
      if (done) begin
        done_rel = rel;
        break;
      end
    end
    res_ready = 1'b1;
  endtask

  task automatic run_to_rel(input int target);
    for (int i = 0; i < 1000 && (cyc - t_acc) < target; i++) step();
    check("reach_rel", 64'(cyc - t_acc), 64'(target));
  endtask

  typedef struct {
    int k;
    int stall;
    int exp_done;
    int exp_rv;
    int exp_r7_first;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int dr, a0, a7, f7;

    tbl[0] = '{k: 1,   stall: 0, exp_done: 46,  exp_rv: 1,   exp_r7_first: 23};
    tbl[1] = '{k: 1,   stall: 5, exp_done: 51,  exp_rv: 1,   exp_r7_first: 23};
    tbl[2] = '{k: 3,   stall: 0, exp_done: 48,  exp_rv: 3,   exp_r7_first: 23};
    tbl[3] = '{k: 255, stall: 2, exp_done: 302, exp_rv: 255, exp_r7_first: 23};
    tbl[4] = '{k: 8,   stall: 3, exp_done: 56,  exp_rv: 8,   exp_r7_first: 23};

    rst = 1'b0; start = 1'b0; k_len = '0; abort = 1'b0; res_ready = 1'b1;
    #2 rst = 1'b1;
    #1 check("reset_outputs", 64'(dut_vec), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    check("idle_busy", 64'(busy), 64'd0);

    // Table-driven tiles.
    for (int i = 0; i < 5; i++) begin
      start_tile(tbl[i].k);
      run_to_done(1000, tbl[i].stall, dr, a0, a7, f7);
      check("tile_done_cycle", 64'(dr), 64'(tbl[i].exp_done));
      check("tile_row0_len", 64'(a0), 64'(tbl[i].exp_rv));
      check("tile_row7_len", 64'(a7), 64'(tbl[i].exp_rv));
      check("tile_row7_first", 64'(f7), 64'(tbl[i].exp_r7_first));
      step();
      check("tile_idle_after", 64'(busy), 64'd0);
    end

    // k_len == 0 start: one-cycle err, no tile.
    start = 1'b1; k_len = '0;
    step();
    start = 1'b0;
    check("err_pulse", 64'({err, busy, sa_load_w}), 64'b100);
    step();
    check("err_cleared", 64'({err, busy}), 64'b00);

    // Abort in STREAM cycle 5, then restart two cycles later.
    start_tile(4);
    run_to_rel(14);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_outputs", 64'(dut_vec), 64'd0);
    step();
    start_tile(2);
    run_to_done(1000, 0, dr, a0, a7, f7);
    check("after_abort_done", 64'(dr), 64'd47);

    // start together with abort in IDLE is accepted; abort beats handshake.
    step();
    start = 1'b1; abort = 1'b1; k_len = 8'd2;
    step();
    start = 1'b0; abort = 1'b0;
    t_acc = cyc - 1; t_k = 2;
    check("idle_abort_start", 64'(busy), 64'd1);
    res_ready = 1'b0;
    for (int i = 0; i < 200 && !res_valid; i++) step();
    check("lo_valid_reached", 64'({res_valid, res_group}), 64'b10);
    res_ready = 1'b1; abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_over_handshake", 64'({busy, done, res_valid}), 64'b000);

    // start pulsed during DRAIN is ignored.
    step();
    start_tile(5);
    run_to_rel(30);
    start = 1'b1; k_len = 8'd9;
    step();
    start = 1'b0;
    run_to_done(1000, 0, dr, a0, a7, f7);
    check("drain_start_ignored", 64'(dr), 64'd50);

    // Reset during DRAIN.
    step();
    start_tile(5);
    run_to_rel(30);
    async_reset();
    for (int i = 0; i < 3; i++) step();
    check("post_reset_idle", 64'(busy), 64'd0);

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      k_len     = ($urandom_range(0, 7) == 0) ? '0 : KW'($urandom_range(1, 16));
      abort     = ($urandom_range(0, 99) == 0);
      res_ready = $urandom_range(0, 1) != 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
